// File: rtl/regfile_pkg.sv
// Shared widths and depth helper for the register file with issue scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  function automatic int depth_of(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/scoreboard_bits.sv
// Busy-bit scoreboard: tracks in-flight writes, flags RAW/WAW hazards and counts pending registers.
module scoreboard_bits
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              issue_ready,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] wr_vec_s;
  logic [DEPTH-1:0] set_vec_s;
  logic [DEPTH-1:0] eff_busy_s;
  logic [ADDR_W:0]  cnt_r;
  logic             ready_s;
  logic             dest_zero_s;
  logic             set_s;
  logic             clr_s;

  // Hazard detection; a same-cycle write-back already resolves its register.
  always_comb begin
    wr_vec_s  = '0;
    set_vec_s = '0;
    if (wr_en) begin
      wr_vec_s[wr_addr] = 1'b1;
    end else begin
      wr_vec_s = '0;
    end
    eff_busy_s  = busy_r & ~wr_vec_s;
    ready_s     = ~(eff_busy_s[rd_addr_a] | eff_busy_s[rd_addr_b] |
                    (issue_valid & eff_busy_s[issue_dest]));
    dest_zero_s = (ZERO_REG != 0) && (issue_dest == {ADDR_W{1'b0}});
    set_s       = issue_valid & ready_s & ~dest_zero_s;
    if (set_s) begin
      set_vec_s[issue_dest] = 1'b1;
    end else begin
      set_vec_s = '0;
    end
    clr_s = wr_en & busy_r[wr_addr];
  end

  // Busy vector and pending count; a new issue to the written register keeps it busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= '0;
      cnt_r  <= '0;
    end else begin
      busy_r <= (busy_r & ~wr_vec_s) | set_vec_s;
      case ({set_s, clr_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign issue_ready = ready_s;
  assign pending_cnt = cnt_r;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass, dedicated PC register
// and an issue scoreboard guarding against RAW/WAW hazards.
module reg_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_ready,
  input  logic              pc_write,
  input  logic [DATA_W-1:0] program_counter,
  output logic [DATA_W-1:0] pc_out,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] pc_r;
  logic              wr_zero_s;
  logic              zero_a_s;
  logic              zero_b_s;

  assign wr_zero_s = (ZERO_REG != 0) && (wr_addr == {ADDR_W{1'b0}});
  assign zero_a_s  = (ZERO_REG != 0) && (rd_addr_a == {ADDR_W{1'b0}});
  assign zero_b_s  = (ZERO_REG != 0) && (rd_addr_b == {ADDR_W{1'b0}});

  // Data array and PC; writes to the hardwired zero register are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      pc_r <= '0;
    end else begin
      if (wr_en && !wr_zero_s) begin
        mem_r[wr_addr] <= wr_data;
      end
      if (pc_write) begin
        pc_r <= program_counter;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // Combinational read ports with write-back bypass.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (zero_a_s) begin
      rd_data_a = '0;
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = mem_r[rd_addr_a];
    end
    if (zero_b_s) begin
      rd_data_b = '0;
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = mem_r[rd_addr_b];
    end
  end

  assign pc_out = pc_r;

  scoreboard_bits #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard_bits (
    .clk         (clk),
    .reset       (reset),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .issue_ready (issue_ready),
    .pending_cnt (pending_cnt)
  );

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 The module SHALL take parameter DATA_W, default 32, giving the register data width in bits.
REQ-002 The module SHALL take parameter ADDR_W, default 5, giving the register address width; DEPTH = 2**ADDR_W registers.
REQ-003 The module SHALL take parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have ports rd_addr_a and rd_addr_b, input, ADDR_W bits each: the read addresses.
REQ-007 The module SHALL have ports rd_data_a and rd_data_b, output, DATA_W bits each: the read data.
REQ-008 The module SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_W) and wr_data (input, DATA_W): the write-back port.
REQ-009 The module SHALL have ports issue_valid (input, 1) and issue_dest (input, ADDR_W): an instruction issue request and its destination register.
REQ-010 The module SHALL have port issue_ready, output, 1 bit: no hazard; issue is accepted this cycle.
REQ-011 The module SHALL have ports pc_write (input, 1), program_counter (input, DATA_W) and pc_out (output, DATA_W): the dedicated PC register.
REQ-012 The module SHALL have port pending_cnt, output, ADDR_W+1 bits: the number of busy registers.

Function
REQ-013 The module SHALL read combinationally: rd_data_x = reg[rd_addr_x] in the same cycle.
REQ-014 The module SHALL bypass writes to reads: if wr_en=1 and wr_addr=rd_addr_x (and the address is not a hardwired zero register), rd_data_x = wr_data.
REQ-015 With ZERO_REG=1, the module SHALL return 0 on reads of register 0, ignore writes to it, and never mark it busy.
REQ-016 The module SHALL keep one busy bit per register; a busy bit means a write to that register is in flight.
REQ-017 The module SHALL accept an issue on a rising edge when issue_valid=1 and issue_ready=1; an accepted issue sets busy[issue_dest].
REQ-018 The module SHALL clear busy[wr_addr] on a rising edge when wr_en=1.
REQ-019 The module SHALL deassert issue_ready when the effective busy bit of rd_addr_a, rd_addr_b or issue_dest is set (RAW and WAW hazards).
REQ-020 The module SHALL compute the effective busy bit as busy[r] AND NOT (wr_en AND wr_addr=r), so that a same-cycle write-back resolves the hazard.
REQ-021 The module SHALL leave busy set when an accepted issue and a write-back target the same register in one cycle (the new issue wins).
REQ-022 The module SHALL increment pending_cnt by 1 on each accepted issue.
REQ-023 The module SHALL decrement pending_cnt by 1 on each write-back to a register whose busy bit is set.
REQ-024 The module SHALL leave pending_cnt unchanged when both an increment and a decrement occur in the same cycle.
REQ-025 The module SHALL treat a write-back to a non-busy register as a plain data update, with no change to any count.
REQ-026 The module SHALL load program_counter into the PC register when pc_write=1; pc_out is registered, with no bypass.
REQ-027 The module SHALL hold issue_ready combinational and ignore issue_dest when issue_valid=0.

Reset
REQ-028 While reset=1 at a rising edge, the module SHALL clear all registers, all busy bits, pc_out and pending_cnt to 0.
REQ-029 The module SHALL give reset priority over write, issue and pc_write in the same cycle; an in-flight write is discarded.
REQ-030 The module SHALL hold issue_ready at 1 in the first cycle after reset.

Structure
REQ-031 The default widths and the DEPTH computation SHALL be shared constants in the core package regfile_pkg.
REQ-032 The design SHALL contain one sub-module, scoreboard_bits, holding the busy vector, the effective-busy logic and pending_cnt; the data array stays in the top module.

Verification
REQ-033 Bypass: write reg5=0xDEADBEEF with rd_addr_a=5 in the same cycle -> rd_data_a=0xDEADBEEF that cycle, and the same value on the next cycle without wr_en.
REQ-034 Zero register: write reg0=0x1234 and issue with issue_dest=0 -> reads of reg0 return 0, issue_ready=1 and pending_cnt=0.
REQ-035 RAW hazard: issue dest=3, then rd_addr_a=3 -> issue_ready=0; in the cycle wr_en=1 and wr_addr=3 -> issue_ready=1, and pending_cnt goes 1->0.
REQ-036 Simultaneous events: reg7 busy; issue dest=7 and wb 7 in the same cycle -> busy[7] stays 1 and pending_cnt stays 1.
REQ-037 Reset mid-operation: 4 pending issues, then reset=1 -> next cycle pending_cnt=0, all reads 0, pc_out=0 and issue_ready=1.
REQ-038 PC: pc_write=1 with program_counter=0x100 -> pc_out=0x100 on the next cycle; with pc_write=0, pc_out holds its value.
